dm_load_ctrl: RTL
=================

# dm_load_ctrl

Read-side counterpart of the store byte-enable path: it accepts a load request from the MEM stage and issues a word-aligned read on the data-memory bus. It waits for the response, then selects and sign- or zero-extends the addressed byte or halfword. It stalls the pipeline for the whole transaction and returns the aligned 32-bit value to WB with a one-cycle valid pulse. It sits between the MEM-stage register and the data-memory/bridge bus port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ+WAIT before the transaction aborts with a bus error. Legal range is 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request from the MEM stage.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- l_op  in  3  load type: 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu. The codes 000, 110 and 111 are invalid.
- addr  in  32  byte address.
- bus_rd_valid  out  1  read command valid.
- bus_addr  out  32  {addr_q[31:2], 2'b00}.
- bus_rd_ready  in  1  the bus accepts the command.
- bus_rdata_valid  in  1  read data present.
- bus_rdata  in  32  read word.
- rdata  out  32  aligned and extended result.
- rdata_valid  out  1  one-cycle completion pulse.
- stall  out  1  high whenever the state is not IDLE.
- adel  out  1  address-error pulse, coincident with rdata_valid.
- bus_err  out  1  timeout pulse, coincident with rdata_valid.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on acceptance, capture l_op, addr and the error flags.
  - Misaligned or invalid op goes to DONE.
  - Otherwise go to REQ.
- REQ: bus_rd_valid = 1 and bus_addr is held stable until bus_rd_ready is sampled high, then go to WAIT.
- WAIT: on bus_rdata_valid, register the extended data and go to DONE. bus_rdata_valid is ignored in every state except WAIT.
- DONE: rdata_valid = 1 for exactly one cycle, then IDLE.
- Extraction rules:
  - lh/lhu: addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16].
  - lb/lbu: addr[1:0]=n selects [8n+7:8n].
  - lh/lb sign-extend from bit 15/7; lhu/lbu zero-extend. lw passes the word through.
- Invalid op: completes with rdata = 0 and no error flags, and performs no bus access.
- Timeout: a 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES-1 without completion, go to DONE with bus_err = 1 and rdata = 0. A late bus_rdata_valid after the abort is ignored.
- Reset value of every output is 0 (req_ready is 1 once the FSM is in IDLE after reset release). Reset in any state returns to IDLE and cancels the transaction with no completion pulse.

## Timing
- Acceptance edge is T0. bus_rd_valid is high from T0+1.
- Minimum latency: with bus_rd_ready at T0+1 and bus_rdata_valid at T0+2, rdata_valid occurs at T0+3.
- Error path (misaligned or invalid): rdata_valid occurs at T0+1.
- req_ready is 0 from T0 until the cycle after DONE, so back-to-back loads are 4 cycles apart at minimum.
- rdata, adel and bus_err are valid only while rdata_valid = 1; they hold their last value otherwise.

## Configuration
- LOAD_ALIGN_CHECK_EN defined: lw with addr[1:0] != 0 or lh/lhu with addr[0] = 1 sets adel, skips the bus, and completes with rdata = 0.
- LOAD_ALIGN_CHECK_EN undefined: no check is made and adel is tied 0. The low address bits are used as given: lw ignores addr[1:0], and halfword loads ignore addr[0].

## Structure
- Shared package: the l_op encodings (LOP_LW, LOP_LH, LOP_LHU, LOP_LB, LOP_LBU) and the state encoding. These encodings are shared with the store byte-enable generator's op definitions.
- Sub-module: load_ext, a pure combinational extractor/extender (l_op, addr[1:0], word in; 32-bit result out), instantiated once in WAIT's capture path.

## Test plan
- lb at addr 0x1003 with bus_rdata 0x80FF_1234 -> rdata 0xFFFF_FF80, rdata_valid at T0+3, bus_addr 0x1000.
- lhu at addr 0x2002 with bus_rdata 0x8001_7FFF -> rdata 0x0000_8001. lh at addr 0x2000 with the same word -> 0x0000_7FFF.
- bus_rd_ready held low 5 cycles, then bus_rdata_valid 3 cycles later -> stall high throughout, bus_addr stable, exactly one rdata_valid.
- TIMEOUT_CYCLES = 8 with no bus response -> bus_err and rdata_valid at T0+8, rdata 0. A bus_rdata_valid injected later is ignored.
- LOAD_ALIGN_CHECK_EN defined, lw at addr 0x3001 -> adel = 1 at T0+1, bus_rd_valid never asserted. Without the macro, the same load returns the word at 0x3000.
- reset asserted while in WAIT -> all outputs 0 immediately, no rdata_valid, req_ready = 1 after reset release.

Source files
------------

// File: rtl/dm_load_ctrl_pkg.sv
// Shared load-op encodings and FSM state type for the data-memory load controller.
// The l_op codes match the store byte-enable generator's op definitions.
package dm_load_ctrl_pkg;

  localparam logic [2:0] LOP_LW  = 3'b001;
  localparam logic [2:0] LOP_LH  = 3'b010;
  localparam logic [2:0] LOP_LHU = 3'b011;
  localparam logic [2:0] LOP_LB  = 3'b100;
  localparam logic [2:0] LOP_LBU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic lop_valid(input logic [2:0] op);
    return (op == LOP_LW) || (op == LOP_LH) || (op == LOP_LHU) ||
           (op == LOP_LB) || (op == LOP_LBU);
  endfunction

endpackage

// File: rtl/dm_load_ctrl_load_ext.sv
// Combinational byte/halfword extractor with sign or zero extension of the read word.
module load_ext
  import dm_load_ctrl_pkg::*;
(
  input  logic [2:0]  l_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    case (l_op)
      LOP_LW:  result = word;
      LOP_LH:  result = {{16{half_sel[15]}}, half_sel};
      LOP_LHU: result = {16'h0000, half_sel};
      LOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LOP_LBU: result = {24'h000000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_load_ctrl.sv
// MEM-stage load controller: word-aligned bus read, extraction/extension, timeout abort.
// Optional alignment check enabled by defining LOAD_ALIGN_CHECK_EN.
module dm_load_ctrl
  import dm_load_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  l_op,
  input  logic [31:0] addr,
  output logic        bus_rd_valid,
  output logic [31:0] bus_addr,
  input  logic        bus_rd_ready,
  input  logic        bus_rdata_valid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stall,
  output logic        adel,
  output logic        bus_err
);

  state_t      state_reg, state_next;
  logic [2:0]  l_op_reg, l_op_next;
  logic [31:0] addr_reg, addr_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        adel_reg, adel_next;
  logic        bus_err_reg, bus_err_next;
  logic        ready_en_reg;
  logic        misaligned;
  logic        accept;
  logic        timed_out;
  logic [31:0] ext_word;

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned = ((l_op == LOP_LW) && (addr[1:0] != 2'b00)) ||
                      (((l_op == LOP_LH) || (l_op == LOP_LHU)) && addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  // ready_en_reg keeps req_ready low while reset is asserted
  assign req_ready = (state_reg == IDLE) && ready_en_reg;
  assign accept    = req_valid && req_ready;

  // The abort edge is the one on which the counter would reach TIMEOUT_CYCLES-1
  assign timed_out = (32'(cnt_reg) + 32'd2) >= TIMEOUT_CYCLES;

  load_ext u_load_ext (
    .l_op    (l_op_reg),
    .addr_lo (addr_reg[1:0]),
    .word    (bus_rdata),
    .result  (ext_word)
  );

  always_comb begin
    state_next   = state_reg;
    l_op_next    = l_op_reg;
    addr_next    = addr_reg;
    cnt_next     = cnt_reg;
    rdata_next   = rdata_reg;
    adel_next    = adel_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          l_op_next = l_op;
          addr_next = addr;
          cnt_next  = '0;
          if (misaligned || !lop_valid(l_op)) begin
            state_next   = DONE;
            rdata_next   = '0;
            adel_next    = misaligned;
            bus_err_next = 1'b0;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_reg + 16'd1;
        if (timed_out) begin
          state_next   = DONE;
          rdata_next   = '0;
          adel_next    = 1'b0;
          bus_err_next = 1'b1;
        end else if (bus_rd_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 16'd1;
        if (bus_rdata_valid) begin
          state_next   = DONE;
          rdata_next   = ext_word;
          adel_next    = 1'b0;
          bus_err_next = 1'b0;
        end else if (timed_out) begin
          state_next   = DONE;
          rdata_next   = '0;
          adel_next    = 1'b0;
          bus_err_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      l_op_reg     <= '0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      adel_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      l_op_reg     <= l_op_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      rdata_reg    <= rdata_next;
      adel_reg     <= adel_next;
      bus_err_reg  <= bus_err_next;
      ready_en_reg <= 1'b1;
    end
  end

  assign bus_rd_valid = (state_reg == REQ);
  assign bus_addr     = {addr_reg[31:2], 2'b00};
  assign rdata_valid  = (state_reg == DONE);
  assign stall        = (state_reg != IDLE);
  assign rdata        = rdata_reg;
  assign adel         = adel_reg;
  assign bus_err      = bus_err_reg;

endmodule
